// File: rtl/register_file_mp_if.sv
// Register-file access bundle: read ports, the single write port and the
// registered results, grouped so datapath stages can hand it around as one.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);

  logic [NUM_READ*ADDR_WIDTH-1:0] iAddrRead;
  logic [NUM_READ-1:0]            iEnRead;
  logic [ADDR_WIDTH-1:0]          iAddrWrite;
  logic [DATA_WIDTH-1:0]          iDataWrite;
  logic                           iEnWrite;
  logic [NUM_READ*DATA_WIDTH-1:0] oDataRead;
  logic [NUM_READ-1:0]            oValidRead;
  logic                           oBusy;

  modport master (
    output iAddrRead, iEnRead, iAddrWrite, iDataWrite, iEnWrite,
    input  oDataRead, oValidRead, oBusy
  );

  modport slave (
    input  iAddrRead, iEnRead, iAddrWrite, iDataWrite, iEnWrite,
    output oDataRead, oValidRead, oBusy
  );

endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port, single-write-port register file with write-to-read bypass,
// optional hardwired zero register and a post-reset clear sweep.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                iClkX2,
  input logic                iRst_n,
  register_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SWEEP_STEP = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                         state;
  logic [ADDR_WIDTH:0]            sweep_count;
  logic [ADDR_WIDTH:0]            sweep_next;
  logic [DATA_WIDTH-1:0]          regs [DEPTH];
  logic [DATA_WIDTH-1:0]          read_result [NUM_READ];
  logic [NUM_READ*DATA_WIDTH-1:0] data_read;
  logic [NUM_READ-1:0]            valid_read;
  logic                           busy;
  logic                           write_zero;
  logic                           write_ok;

  assign write_zero = (ZERO_REG != 0) && (bus.iAddrWrite == '0);
  assign write_ok   = (state == RUN) && bus.iEnWrite && !write_zero;
  assign sweep_next = sweep_count + SWEEP_STEP;

  // Per-port read selection: zero register, then same-cycle bypass, then array.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      logic [ADDR_WIDTH-1:0] addr;
      addr = bus.iAddrRead[p*ADDR_WIDTH +: ADDR_WIDTH];
      read_result[p] = regs[addr];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        read_result[p] = '0;
      end else if ((BYPASS != 0) && write_ok && (bus.iAddrWrite == addr)) begin
        read_result[p] = bus.iDataWrite;
      end
    end
  end

  // Sweep counter MSB marks the last cleared entry, so the counter parks in RUN.
  always_ff @(posedge iClkX2) begin
    if (!iRst_n) begin
      state       <= CLEAR;
      sweep_count <= '0;
      busy        <= 1'b1;
      data_read   <= '0;
      valid_read  <= '0;
    end else begin
      for (int p = 0; p < NUM_READ; p++) begin
        valid_read[p] <= bus.iEnRead[p];
        if (bus.iEnRead[p]) begin
          data_read[p*DATA_WIDTH +: DATA_WIDTH] <= (state == CLEAR) ? '0 : read_result[p];
        end
      end
      case (state)
        CLEAR: begin
          sweep_count <= sweep_next;
          if (sweep_next[ADDR_WIDTH]) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge iClkX2) begin
    if (iRst_n) begin
      if (state == CLEAR) begin
        regs[sweep_count[ADDR_WIDTH-1:0]] <= '0;
      end else if (write_ok) begin
        regs[bus.iAddrWrite] <= bus.iDataWrite;
      end
    end
  end

  assign bus.oDataRead  = data_read;
  assign bus.oValidRead = valid_read;
  assign bus.oBusy      = busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Drives two register-file configurations from one stimulus stream and checks
// every output each cycle against a behavioural model of the file.
module tb_register_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [4*AW-1:0] addr_rd;
  logic [3:0]      en_rd;
  logic [AW-1:0]   addr_wr;
  logic [DW-1:0]   data_wr;
  logic            en_wr;

  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2)) bus_a ();
  register_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(4)) bus_b ();

  assign bus_a.iAddrRead  = addr_rd[2*AW-1:0];
  assign bus_a.iEnRead    = en_rd[1:0];
  assign bus_a.iAddrWrite = addr_wr;
  assign bus_a.iDataWrite = data_wr;
  assign bus_a.iEnWrite   = en_wr;
  assign bus_b.iAddrRead  = addr_rd;
  assign bus_b.iEnRead    = en_rd;
  assign bus_b.iAddrWrite = addr_wr;
  assign bus_b.iDataWrite = data_wr;
  assign bus_b.iEnWrite   = en_wr;

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .iClkX2(clk),
    .iRst_n(rst_n),
    .bus   (bus_a.slave)
  );

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(4), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .iClkX2(clk),
    .iRst_n(rst_n),
    .bus   (bus_b.slave)
  );

  // Model state, index 0 = dut_a (zero reg, bypass), 1 = dut_b (neither).
  logic [DW-1:0] ref_mem   [2][DEPTH];
  logic [DW-1:0] ref_data  [2][4];
  logic          ref_valid [2][4];
  logic          ref_busy  [2];
  int            ref_sweep [2];
  int            ports     [2] = '{2, 4};
  bit            zero_cfg  [2] = '{1'b1, 1'b0};
  bit            byp_cfg   [2] = '{1'b1, 1'b0};

  int pass_count  = 0;
  int check_count = 0;

  function automatic logic [4*AW-1:0] rd4(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ref_busy[d]  = 1'b1;
        ref_sweep[d] = 0;
        for (int p = 0; p < 4; p++) begin
          ref_data[d][p]  = '0;
          ref_valid[d][p] = 1'b0;
        end
      end else begin
        bit wr_ok;
        wr_ok = en_wr && !ref_busy[d] && !(zero_cfg[d] && addr_wr == '0);
        for (int p = 0; p < ports[d]; p++) begin
          logic [AW-1:0] a;
          a = addr_rd[p*AW +: AW];
          ref_valid[d][p] = en_rd[p];
          if (en_rd[p]) begin
            if (ref_busy[d] || (zero_cfg[d] && a == '0))
              ref_data[d][p] = '0;
            else if (byp_cfg[d] && wr_ok && a == addr_wr)
              ref_data[d][p] = data_wr;
            else
              ref_data[d][p] = ref_mem[d][a];
          end
        end
        if (ref_busy[d]) begin
          ref_mem[d][ref_sweep[d]] = '0;
          ref_sweep[d] = ref_sweep[d] + 1;
          if (ref_sweep[d] == DEPTH) ref_busy[d] = 1'b0;
        end else if (wr_ok) begin
          ref_mem[d][addr_wr] = data_wr;
        end
      end
    end
  endtask

  task automatic compare(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] obs_data(input int d, input int p);
    return (d == 0) ? bus_a.oDataRead[p*DW +: DW] : bus_b.oDataRead[p*DW +: DW];
  endfunction

  task automatic check_output(input string tag);
    compare($sformatf("%s/a/busy", tag), {31'b0, bus_a.oBusy}, {31'b0, ref_busy[0]});
    compare($sformatf("%s/b/busy", tag), {31'b0, bus_b.oBusy}, {31'b0, ref_busy[1]});
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < ports[d]; p++) begin
        logic v;
        v = (d == 0) ? bus_a.oValidRead[p] : bus_b.oValidRead[p];
        compare($sformatf("%s/%0d/valid%0d", tag, d, p), {31'b0, v}, {31'b0, ref_valid[d][p]});
        compare($sformatf("%s/%0d/data%0d", tag, d, p), obs_data(d, p), ref_data[d][p]);
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [3:0] en, input logic [4*AW-1:0] ra,
                                input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input string tag);
    rst_n   = rst;
    en_rd   = en;
    addr_rd = ra;
    en_wr   = we;
    addr_wr = wa;
    data_wr = wd;
    model_edge();
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  task automatic sweep_and_readback(input string tag);
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1'b1, 4'($urandom), 20'($urandom), 1'b1, 5'($urandom), $urandom, {tag, "_sweep"});
    for (int i = 0; i < DEPTH / 4; i++)
      apply_stimulus(1'b1, 4'b1111, rd4(5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3)),
                     1'b0, '0, '0, {tag, "_readback"});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
      ref_busy[d]  = 1'b1;
      ref_sweep[d] = 0;
    end

    repeat (3) apply_stimulus(1'b0, 4'b1111, '0, 1'b1, 5'd1, 32'h1, "reset");

    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1'b1, 4'b1111, rd4(5'(i % 31 + 1), 5'(30 - i % 31 + 1), 5'd3, 5'd31),
                     (i == 5), 5'd3, 32'hDEADBEEF, "clear");

    apply_stimulus(1'b1, 4'b0000, '0, 1'b1, 5'd5, 32'h12345678, "wr5");
    apply_stimulus(1'b1, 4'b0011, rd4(5'd5, 5'd5, 5'd0, 5'd0), 1'b1, 5'd7, 32'h11111111, "rd5");
    compare("rd5_both_a", obs_data(0, 1), 32'h12345678);
    apply_stimulus(1'b1, 4'b1111, rd4(5'd7, 5'd7, 5'd7, 5'd7), 1'b1, 5'd7, 32'hA5A5A5A5, "bypass7");
    compare("bypass7_a", obs_data(0, 0), 32'hA5A5A5A5);
    compare("bypass7_b", obs_data(1, 0), 32'h11111111);
    apply_stimulus(1'b1, 4'b0011, rd4(5'd7, 5'd7, 5'd0, 5'd0), 1'b0, '0, '0, "reread7");
    compare("reread7_b", obs_data(1, 1), 32'hA5A5A5A5);
    apply_stimulus(1'b1, 4'b0011, rd4(5'd0, 5'd0, 5'd0, 5'd0), 1'b1, 5'd0, 32'hFFFFFFFF, "zero_wr");
    apply_stimulus(1'b1, 4'b1111, rd4(5'd0, 5'd0, 5'd0, 5'd0), 1'b0, '0, '0, "zero_rd");
    compare("zero_rd_a", obs_data(0, 0), 32'h0);
    compare("zero_rd_b", obs_data(1, 0), 32'hFFFFFFFF);
    apply_stimulus(1'b1, 4'b0011, rd4(5'd5, 5'd5, 5'd0, 5'd0), 1'b0, '0, '0, "rd5b");
    apply_stimulus(1'b1, 4'b0001, rd4(5'd5, 5'd5, 5'd0, 5'd0), 1'b1, 5'd5, 32'h0, "hold");
    apply_stimulus(1'b1, 4'b0001, rd4(5'd5, 5'd5, 5'd0, 5'd0), 1'b0, '0, '0, "hold2");
    compare("hold_port1", obs_data(0, 1), 32'h12345678);
    apply_stimulus(1'b1, 4'b0001, rd4(5'd3, 5'd0, 5'd0, 5'd0), 1'b0, '0, '0, "drop3");

    apply_stimulus(1'b1, 4'b0000, '0, 1'b1, 5'd9, 32'h99990009, "wr9");
    apply_stimulus(1'b1, 4'b0000, '0, 1'b1, 5'd10, 32'hAAAA000A, "wr10");
    apply_stimulus(1'b1, 4'b1111, rd4(5'd9, 5'd10, 5'd7, 5'd5), 1'b0, '0, '0, "four_ports");
    compare("four_ports_b2", obs_data(1, 2), 32'hA5A5A5A5);

    for (int i = 0; i < 400; i++)
      apply_stimulus(1'b1, 4'($urandom),
                     rd4(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                     1'($urandom), 5'($urandom_range(0, 7)), $urandom, "random");

    apply_stimulus(1'b0, 4'b0000, '0, 1'b0, '0, '0, "rst_run");
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'b1, 4'($urandom), 20'($urandom), 1'b1, 5'($urandom), $urandom, "partial_sweep");
    apply_stimulus(1'b0, 4'b1111, '0, 1'b0, '0, '0, "rst_mid_sweep");
    sweep_and_readback("after_mid_reset");

    for (int i = 0; i < 40; i++)
      apply_stimulus(1'b1, 4'($urandom), 20'($urandom), 1'b1, 5'($urandom), $urandom, "fill");
    apply_stimulus(1'b0, 4'b1111, '0, 1'b1, 5'd4, 32'h4, "rst_in_run");
    apply_stimulus(1'b0, 4'b1111, '0, 1'b1, 5'd4, 32'h4, "rst_in_run");
    sweep_and_readback("after_run_reset");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
